// File: rtl/seg_scan_display_if.sv
// Debug-word display bus: two 32-bit words, page/freeze controls,
// segment and digit-enable outputs.
interface seg_scan_display_if #(
  parameter int NUM_DIGITS = 8
);
  logic [31:0]           ValueA;
  logic [31:0]           ValueB;
  logic [1:0]            Page;
  logic                  Freeze;
  logic [6:0]            out7;
  logic [NUM_DIGITS-1:0] en_out;
  logic                  FrameStart;

  modport master (
    output ValueA, ValueB, Page, Freeze,
    input  out7, en_out, FrameStart
  );

  modport slave (
    input  ValueA, ValueB, Page, Freeze,
    output out7, en_out, FrameStart
  );
endinterface

// File: rtl/seg_scan_display.sv
// Time-multiplexed hex scan display for two debug words.
// Optional SEG_LZB_EN: per-group leading-zero blanking.
module seg_scan_display #(
  parameter int NUM_DIGITS   = 8,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000,
  parameter bit ACTIVE_LOW   = 1'b1
) (
  input logic          Clk,
  input logic          Reset,
  seg_scan_display_if.slave bus
);

  localparam int H  = NUM_DIGITS / 2;
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int PW = $clog2(REFRESH_DIV);

  logic [PW-1:0]         presc;
  logic [IW-1:0]         idx;
  logic [31:0]           sha;
  logic [31:0]           shb;
  logic [1:0]            page_q;
  logic                  fs_q;
  logic [6:0]            seg_q;
  logic [NUM_DIGITS-1:0] en_q;

  logic                  tick;
  logic                  snap;
  logic                  grp_b;
  logic                  show;
  logic [2:0]            n_sel;
  logic [2:0]            off_nib;
  logic [2:0]            win_sel;
  logic [31:0]           word;
  logic [3:0]            nib;
  logic [6:0]            seg_on;
  logic [6:0]            seg_d;
  logic [NUM_DIGITS-1:0] en_on;
  logic [NUM_DIGITS-1:0] en_d;

  function automatic logic [6:0] glyph(input logic [3:0] v);
    logic [6:0] g;
    unique case (v)
      4'h0: g = 7'b1111110;
      4'h1: g = 7'b0110000;
      4'h2: g = 7'b1101101;
      4'h3: g = 7'b1111001;
      4'h4: g = 7'b0110011;
      4'h5: g = 7'b1011011;
      4'h6: g = 7'b1011111;
      4'h7: g = 7'b1110000;
      4'h8: g = 7'b1111111;
      4'h9: g = 7'b1111011;
      4'hA: g = 7'b1110111;
      4'hB: g = 7'b0011111;
      4'hC: g = 7'b1001110;
      4'hD: g = 7'b0111101;
      4'hE: g = 7'b1001111;
      4'hF: g = 7'b1000111;
    endcase
    return g;
  endfunction

  always_comb begin
    tick    = presc == PW'(REFRESH_DIV - 1);
    snap    = tick && (idx == IW'(NUM_DIGITS - 1))
              && !bus.Freeze;
    grp_b   = idx < IW'(H);
    word    = grp_b ? shb : sha;
    n_sel   = grp_b ? 3'(idx) : 3'(idx - IW'(H));
    // Window offset in nibbles; wraps mod 8 nibbles (32 bits).
    off_nib = 3'(32'(page_q) * H);
    win_sel = n_sel + off_nib;
    nib     = word[{win_sel, 2'b00} +: 4];
`ifdef SEG_LZB_EN
    show = n_sel == 3'd0;
    for (int k = 0; k < H; k++) begin
      if (3'(k) >= n_sel &&
          word[{3'(k) + off_nib, 2'b00} +: 4] != 4'h0)
        show = 1'b1;
    end
`else
    show = 1'b1;
`endif
    seg_on = show ? glyph(nib) : 7'b0;
    en_on  = (presc < PW'(BLANK_CYCLES))
             ? '0
             : (NUM_DIGITS'(1) << idx);
    seg_d  = ACTIVE_LOW ? ~seg_on : seg_on;
    en_d   = ACTIVE_LOW ? ~en_on : en_on;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      presc  <= '0;
      idx    <= '0;
      sha    <= '0;
      shb    <= '0;
      page_q <= '0;
      fs_q   <= 1'b0;
      seg_q  <= ACTIVE_LOW ? '1 : '0;
      en_q   <= ACTIVE_LOW ? '1 : '0;
    end else begin
      presc <= tick ? '0 : presc + 1'b1;
      if (tick)
        idx <= (idx == IW'(NUM_DIGITS - 1))
               ? '0 : idx + 1'b1;
      fs_q <= snap;
      if (snap) begin
        sha    <= bus.ValueA;
        shb    <= bus.ValueB;
        page_q <= bus.Page;
      end
      seg_q <= seg_d;
      en_q  <= en_d;
    end
  end

  assign bus.out7       = seg_q;
  assign bus.en_out     = en_q;
  assign bus.FrameStart = fs_q;

endmodule

// File: tb/tb_seg_scan_display.sv
// Self-checking bench for seg_scan_display against a
// time-based reference model (8 digits, active-low).
module tb_seg_scan_display;

  localparam int ND    = 8;
  localparam int RD    = 4;
  localparam int BL    = 1;
  localparam int H     = ND / 2;
  localparam int FRAME = ND * RD;

  logic Clk = 1'b0;
  logic Reset = 1'b1;

  seg_scan_display_if #(.NUM_DIGITS(ND)) bus ();

  seg_scan_display #(
    .NUM_DIGITS  (ND),
    .REFRESH_DIV (RD),
    .BLANK_CYCLES(BL),
    .ACTIVE_LOW  (1'b1)
  ) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .bus  (bus)
  );

  always #5 Clk = ~Clk;

  int total = 0;
  int bad   = 0;

  logic [6:0] glyph [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  int          m_t;
  logic [31:0] m_a;
  logic [31:0] m_b;
  int          m_page;
  logic [7:0]  exp_en;
  logic [6:0]  exp_seg;
  logic        exp_fs;

  function automatic logic [3:0] nib_of(
    input logic [31:0] w, input int page, input int n);
    logic [63:0] d;
    int off;
    off = (page * 4 * H) % 32;
    d = {w, w} >> (off + 4 * n);
    return d[3:0];
  endfunction

  function automatic bit shown(
    input logic [31:0] w, input int page, input int n);
    if (n == 0) return 1'b1;
    for (int k = n; k < H; k++)
      if (nib_of(w, page, k) != 4'h0) return 1'b1;
    return 1'b0;
  endfunction

  // Model predicts the outputs produced by the coming edge
  // from time-within-frame arithmetic, then advances one cycle.
  task automatic cyc();
    int slot, ph, n;
    logic [31:0] w;
    if (Reset) begin
      exp_en = 8'hFF; exp_seg = 7'h7F; exp_fs = 1'b0;
      m_t = 0; m_a = '0; m_b = '0; m_page = 0;
    end else begin
      slot = (m_t / RD) % ND;
      ph   = m_t % RD;
      exp_en = (ph < BL) ? 8'hFF : ~(8'h01 << slot);
      w = (slot < H) ? m_b : m_a;
      n = (slot < H) ? slot : slot - H;
      exp_seg = ~glyph[nib_of(w, m_page, n)];
`ifdef SEG_LZB_EN
      if (!shown(w, m_page, n)) exp_seg = 7'h7F;
`endif
      exp_fs = (m_t % FRAME == FRAME - 1) && !bus.Freeze;
      if (exp_fs) begin
        m_a = bus.ValueA; m_b = bus.ValueB;
        m_page = int'(bus.Page);
      end
      m_t++;
    end
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    bus.ValueA = '0; bus.ValueB = '0;
    bus.Page = '0; bus.Freeze = 1'b0;
    Reset = 1'b1;
    cyc();
    cyc();
    total++;
    if (bus.en_out !== 8'hFF) begin
      bad++;
      $display("FAIL reset_en got=%h exp=ff", bus.en_out);
    end
    total++;
    if (bus.out7 !== 7'h7F) begin
      bad++;
      $display("FAIL reset_seg got=%h exp=7f", bus.out7);
    end
    total++;
    if (bus.FrameStart !== 1'b0) begin
      bad++;
      $display("FAIL reset_fs got=%b exp=0", bus.FrameStart);
    end
    Reset = 1'b0;
  endtask

  task automatic test_zero_frame();
    int blanks = 0;
    for (int i = 0; i < FRAME; i++) begin
      cyc();
      total++;
      if ({bus.en_out, bus.out7, bus.FrameStart} !==
          {exp_en, exp_seg, exp_fs}) begin
        bad++;
        $display("FAIL zero_frame c%0d got=%h/%h/%b exp=%h/%h/%b",
          i, bus.en_out, bus.out7, bus.FrameStart,
          exp_en, exp_seg, exp_fs);
      end
      if (bus.en_out === 8'hFF) blanks++;
      else begin
        total++;
        if (bus.out7 !== 7'b0000001) begin
          bad++;
          $display("FAIL zero_glyph got=%b exp=0000001", bus.out7);
        end
      end
    end
    total++;
    if (blanks != ND) begin
      bad++;
      $display("FAIL blank_slots got=%0d exp=%0d", blanks, ND);
    end
  endtask

  task automatic test_snapshot();
    int fs_seen = 0;
    bit found = 0;
    bus.ValueA = 32'h0040_00A8;
    bus.ValueB = 32'h1234_ABCD;
    bus.Page = 2'd0;
    for (int i = 0; i < 40 && !found; i++) begin
      cyc();
      total++;
      if ({bus.en_out, bus.out7, bus.FrameStart} !==
          {exp_en, exp_seg, exp_fs}) begin
        bad++;
        $display("FAIL snap_wait got=%h/%h/%b exp=%h/%h/%b",
          bus.en_out, bus.out7, bus.FrameStart,
          exp_en, exp_seg, exp_fs);
      end
      if (bus.FrameStart === 1'b1) fs_seen++;
      found = exp_fs;
    end
    total++;
    if (!found || fs_seen != 1) begin
      bad++;
      $display("FAIL snap_pulse got=%0d exp=1", fs_seen);
    end
    for (int i = 0; i < FRAME; i++) begin
      cyc();
      total++;
      if ({bus.en_out, bus.out7, bus.FrameStart} !==
          {exp_en, exp_seg, exp_fs}) begin
        bad++;
        $display("FAIL snap_frame got=%h/%h/%b exp=%h/%h/%b",
          bus.en_out, bus.out7, bus.FrameStart,
          exp_en, exp_seg, exp_fs);
      end
      if (bus.en_out === 8'hFB) begin
        total++;
        if (bus.out7 !== 7'b1100000) begin
          bad++;
          $display("FAIL digit2_b got=%b exp=1100000", bus.out7);
        end
      end
      if (bus.en_out === 8'hF7) begin
        total++;
        if (bus.out7 !== 7'b0001000) begin
          bad++;
          $display("FAIL digit3_A got=%b exp=0001000", bus.out7);
        end
      end
    end
  endtask

  task automatic test_page();
    bit found = 0;
    bus.Page = 2'd1;
    for (int i = 0; i < 40 && !found; i++) begin
      cyc();
      total++;
      if ({bus.en_out, bus.out7, bus.FrameStart} !==
          {exp_en, exp_seg, exp_fs}) begin
        bad++;
        $display("FAIL page_wait got=%h/%h/%b exp=%h/%h/%b",
          bus.en_out, bus.out7, bus.FrameStart,
          exp_en, exp_seg, exp_fs);
      end
      found = exp_fs;
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL page_timeout got=0 exp=1");
    end
    for (int i = 0; i < FRAME; i++) begin
      cyc();
      total++;
      if ({bus.en_out, bus.out7, bus.FrameStart} !==
          {exp_en, exp_seg, exp_fs}) begin
        bad++;
        $display("FAIL page_frame got=%h/%h/%b exp=%h/%h/%b",
          bus.en_out, bus.out7, bus.FrameStart,
          exp_en, exp_seg, exp_fs);
      end
      if (bus.en_out === 8'hDF) begin
        total++;
        if (bus.out7 !== 7'b1001100) begin
          bad++;
          $display("FAIL digit5_4 got=%b exp=1001100", bus.out7);
        end
      end
    end
  endtask

  task automatic test_freeze();
    int fs_cnt = 0;
    bit found = 0;
    bus.Freeze = 1'b1;
    bus.ValueB = 32'hFFFF_FFFF;
    for (int i = 0; i < 40; i++) begin
      cyc();
      total++;
      if ({bus.en_out, bus.out7, bus.FrameStart} !==
          {exp_en, exp_seg, exp_fs}) begin
        bad++;
        $display("FAIL freeze_hold got=%h/%h/%b exp=%h/%h/%b",
          bus.en_out, bus.out7, bus.FrameStart,
          exp_en, exp_seg, exp_fs);
      end
      if (bus.FrameStart === 1'b1) fs_cnt++;
    end
    total++;
    if (fs_cnt != 0) begin
      bad++;
      $display("FAIL freeze_fs got=%0d exp=0", fs_cnt);
    end
    bus.Freeze = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      cyc();
      total++;
      if ({bus.en_out, bus.out7, bus.FrameStart} !==
          {exp_en, exp_seg, exp_fs}) begin
        bad++;
        $display("FAIL unfreeze_wait got=%h/%h/%b exp=%h/%h/%b",
          bus.en_out, bus.out7, bus.FrameStart,
          exp_en, exp_seg, exp_fs);
      end
      found = exp_fs;
    end
    for (int i = 0; i < FRAME; i++) begin
      cyc();
      total++;
      if ({bus.en_out, bus.out7, bus.FrameStart} !==
          {exp_en, exp_seg, exp_fs}) begin
        bad++;
        $display("FAIL unfreeze_frame got=%h/%h/%b exp=%h/%h/%b",
          bus.en_out, bus.out7, bus.FrameStart,
          exp_en, exp_seg, exp_fs);
      end
      if (bus.en_out === 8'hFE) begin
        total++;
        if (bus.out7 !== 7'b0111000) begin
          bad++;
          $display("FAIL digit0_F got=%b exp=0111000", bus.out7);
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    bit found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      found = ((m_t / RD) % ND == 5) && (m_t % RD == 2);
      if (!found) cyc();
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL midrst_timeout got=0 exp=1");
    end
    Reset = 1'b1;
    cyc();
    total++;
    if ({bus.en_out, bus.out7, bus.FrameStart} !==
        {8'hFF, 7'h7F, 1'b0}) begin
      bad++;
      $display("FAIL midrst_out got=%h/%h/%b exp=ff/7f/0",
        bus.en_out, bus.out7, bus.FrameStart);
    end
    Reset = 1'b0;
    cyc();
    cyc();
    total++;
    if (bus.en_out !== 8'hFE) begin
      bad++;
      $display("FAIL midrst_idx got=%h exp=fe", bus.en_out);
    end
    for (int i = 0; i < FRAME - 3; i++) begin
      cyc();
      total++;
      if ({bus.en_out, bus.out7, bus.FrameStart} !==
          {exp_en, exp_seg, exp_fs}) begin
        bad++;
        $display("FAIL midrst_frame got=%h/%h/%b exp=%h/%h/%b",
          bus.en_out, bus.out7, bus.FrameStart,
          exp_en, exp_seg, exp_fs);
      end
      if (bus.en_out !== 8'hFF) begin
        total++;
        if (bus.out7 !== 7'b0000001) begin
          bad++;
          $display("FAIL midrst_clr got=%b exp=0000001", bus.out7);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int f = 0; f < 6; f++) begin
      bus.ValueA = $urandom;
      bus.ValueB = $urandom;
      bus.Page   = 2'($urandom_range(0, 3));
      bus.Freeze = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < FRAME + 5; i++) begin
        cyc();
        total++;
        if ({bus.en_out, bus.out7, bus.FrameStart} !==
            {exp_en, exp_seg, exp_fs}) begin
          bad++;
          $display("FAIL random f%0d got=%h/%h/%b exp=%h/%h/%b",
            f, bus.en_out, bus.out7, bus.FrameStart,
            exp_en, exp_seg, exp_fs);
        end
      end
    end
    bus.Freeze = 1'b0;
  endtask

  task automatic test_leading_zero();
    bit found = 0;
    logic [6:0] lead;
`ifdef SEG_LZB_EN
    lead = 7'h7F;
`else
    lead = 7'b0000001;
`endif
    bus.ValueA = 32'h0000_0007;
    bus.ValueB = $urandom;
    bus.Page = 2'd0;
    for (int i = 0; i < 40 && !found; i++) begin
      cyc();
      found = exp_fs;
    end
    for (int i = 0; i < FRAME; i++) begin
      cyc();
      total++;
      if ({bus.en_out, bus.out7, bus.FrameStart} !==
          {exp_en, exp_seg, exp_fs}) begin
        bad++;
        $display("FAIL lzb_frame got=%h/%h/%b exp=%h/%h/%b",
          bus.en_out, bus.out7, bus.FrameStart,
          exp_en, exp_seg, exp_fs);
      end
      if (bus.en_out === 8'h7F || bus.en_out === 8'hBF ||
          bus.en_out === 8'hDF) begin
        total++;
        if (bus.out7 !== lead) begin
          bad++;
          $display("FAIL lzb_lead en=%h got=%b exp=%b",
            bus.en_out, bus.out7, lead);
        end
      end
      if (bus.en_out === 8'hEF) begin
        total++;
        if (bus.out7 !== 7'b0001111) begin
          bad++;
          $display("FAIL lzb_digit4 got=%b exp=0001111", bus.out7);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_zero_frame();
    test_snapshot();
    test_page();
    test_freeze();
    test_mid_reset();
    test_random();
    test_leading_zero();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
